// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: producer-side hazard tracker beside the ID/EX registers.
// Tracks in-flight register writers (ID issue -> WB commit) and loads in
// EX/MEM. Raises stall/bubble controls for load-use, multi-cycle EX ops and
// writer-count saturation.
// Ports:
//   aclk, aresetn                      clock, async active-low reset
//   id_valid, id_flush                 ID instruction present / killed
//   id_rj/rk/rd_no, id_rj/rk/rd_re     ID register numbers and read enables
//   id_we, id_is_load, id_is_multi     ID instruction attributes
//   ex_finish                          multi-cycle EX op completes
//   wb_we, wb_rd_no                    WB register commit
//   stall_id, stall_ex, bubble_ex      pipeline controls (combinational)
//   id_fire, ex_busy                   issue strobe, multi-cycle op in flight
//   err_timeout, err_underflow         sticky error flags
module hazard_scoreboard #(
  parameter int unsigned NREG        = 32,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             id_valid,
  input  logic             id_flush,
  input  logic [REG_W-1:0] id_rj_no,
  input  logic [REG_W-1:0] id_rk_no,
  input  logic [REG_W-1:0] id_rd_no,
  input  logic             id_rj_re,
  input  logic             id_rk_re,
  input  logic             id_rd_re,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             id_is_multi,
  input  logic             ex_finish,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_rd_no,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             id_fire,
  output logic             ex_busy,
  output logic             err_timeout,
  output logic             err_underflow
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state;
  logic [TO_W-1:0]  to_cnt;

  logic             ld_ex_v;
  logic [REG_W-1:0] ld_ex_rd;
  logic             ld_mem_v;
  logic [REG_W-1:0] ld_mem_rd;

  logic [CNT_W-1:0] pend_cnt [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;

  logic             load_haz;
  logic             sat_haz;
  logic             wb_dec;

  // A source hits a tracker only when read, nonzero and the tracker is valid.
  function automatic logic src_hit(input logic re, input logic [REG_W-1:0] src,
                                   input logic vld, input logic [REG_W-1:0] trk);
    return re && (src != '0) && vld && (src == trk);
  endfunction

  // Load-use: a load in EX or MEM has no forwardable data yet.
  always_comb begin
    load_haz = src_hit(id_rj_re, id_rj_no, ld_ex_v,  ld_ex_rd)
             | src_hit(id_rk_re, id_rk_no, ld_ex_v,  ld_ex_rd)
             | src_hit(id_rd_re, id_rd_no, ld_ex_v,  ld_ex_rd)
             | src_hit(id_rj_re, id_rj_no, ld_mem_v, ld_mem_rd)
             | src_hit(id_rk_re, id_rk_no, ld_mem_v, ld_mem_rd)
             | src_hit(id_rd_re, id_rd_no, ld_mem_v, ld_mem_rd);
  end

  assign wb_dec  = wb_we & (wb_rd_no != '0);

  // A same-cycle commit to rd frees a slot, so the writer need not wait.
  assign sat_haz = id_we & (id_rd_no != '0) & (pend_cnt[id_rd_no] == CNT_MAX)
                 & ~(wb_dec & (wb_rd_no == id_rd_no));

  // Outputs are combinational; aresetn gating keeps them all low in reset.
  assign ex_busy   = (state == BUSY);
  assign stall_ex  = aresetn & ex_busy & ~ex_finish;
  assign stall_id  = aresetn & id_valid & ~id_flush & (load_haz | sat_haz | stall_ex);
  assign id_fire   = aresetn & id_valid & ~id_flush & ~stall_id;
  assign bubble_ex = aresetn & ~stall_ex & ~id_fire;

  // One-hot increment/decrement requests; bit 0 is never set.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (id_fire && id_we && (id_rd_no != '0)) inc_vec[id_rd_no] = 1'b1;
    if (wb_dec) dec_vec[wb_rd_no] = 1'b1;
  end

  // Multi-cycle EX FSM with saturating timeout counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (state == IDLE) begin
      if (id_fire && id_is_multi) begin
        state  <= BUSY;
        to_cnt <= '0;
      end
    end else begin
      if (ex_finish) state <= IDLE;
      if (to_cnt != TO_W'(TIMEOUT_CYC)) to_cnt <= to_cnt + TO_W'(1);
      if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) err_timeout <= 1'b1;
    end
  end

  // Load trackers follow the EX/MEM pipeline and freeze with it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ld_ex_v   <= 1'b0;
      ld_ex_rd  <= '0;
      ld_mem_v  <= 1'b0;
      ld_mem_rd <= '0;
    end else if (!stall_ex) begin
      ld_mem_v  <= ld_ex_v;
      ld_mem_rd <= ld_ex_rd;
      ld_ex_v   <= id_fire & id_is_load & id_we & (id_rd_no != '0);
      ld_ex_rd  <= id_rd_no;
    end
  end

  // Pending-writer counters; a balanced inc/dec leaves the count alone.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned r = 0; r < NREG; r++) pend_cnt[r] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          pend_cnt[r] <= pend_cnt[r] + CNT_W'(1);
        end else if (dec_vec[r] && !inc_vec[r] && (pend_cnt[r] != '0)) begin
          pend_cnt[r] <= pend_cnt[r] - CNT_W'(1);
        end
      end
      if (wb_dec && !inc_vec[wb_rd_no] && (pend_cnt[wb_rd_no] == '0)) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: expected control vectors are queued as
// stimulus is applied and popped when the outputs are sampled.
module tb_hazard_scoreboard;

  logic       aclk;
  logic       aresetn;
  logic       id_valid, id_flush;
  logic [4:0] id_rj_no, id_rk_no, id_rd_no;
  logic       id_rj_re, id_rk_re, id_rd_re;
  logic       id_we, id_is_load, id_is_multi;
  logic       ex_finish;
  logic       wb_we;
  logic [4:0] wb_rd_no;
  logic       stall_id, stall_ex, bubble_ex, id_fire, ex_busy;
  logic       err_timeout, err_underflow;

  int passed = 0;
  int total  = 0;
  logic [4:0] exp_q [$];
  logic [4:0] exp_v;

  hazard_scoreboard dut (
    .aclk(aclk), .aresetn(aresetn),
    .id_valid(id_valid), .id_flush(id_flush),
    .id_rj_no(id_rj_no), .id_rk_no(id_rk_no), .id_rd_no(id_rd_no),
    .id_rj_re(id_rj_re), .id_rk_re(id_rk_re), .id_rd_re(id_rd_re),
    .id_we(id_we), .id_is_load(id_is_load), .id_is_multi(id_is_multi),
    .ex_finish(ex_finish), .wb_we(wb_we), .wb_rd_no(wb_rd_no),
    .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
    .id_fire(id_fire), .ex_busy(ex_busy),
    .err_timeout(err_timeout), .err_underflow(err_underflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // {stall_id, stall_ex, bubble_ex, id_fire, ex_busy}
  function automatic logic [4:0] obs();
    return {stall_id, stall_ex, bubble_ex, id_fire, ex_busy};
  endfunction

  task automatic clr();
    id_valid = 0; id_flush = 0;
    id_rj_no = 0; id_rk_no = 0; id_rd_no = 0;
    id_rj_re = 0; id_rk_re = 0; id_rd_re = 0;
    id_we = 0; id_is_load = 0; id_is_multi = 0;
    ex_finish = 0; wb_we = 0; wb_rd_no = 0;
  endtask

  // Start a cycle: wait for the falling edge and clear all drives.
  task automatic cyc();
    @(negedge aclk);
    clr();
  endtask

  task automatic drive_id(input logic [4:0] rj, input logic rjre,
                          input logic [4:0] rk, input logic rkre,
                          input logic [4:0] rd, input logic rdre,
                          input logic we, input logic ld, input logic mul);
    id_valid = 1;
    id_rj_no = rj; id_rj_re = rjre;
    id_rk_no = rk; id_rk_re = rkre;
    id_rd_no = rd; id_rd_re = rdre;
    id_we = we; id_is_load = ld; id_is_multi = mul;
  endtask

  task automatic commit(input logic [4:0] r);
    cyc();
    wb_we = 1; wb_rd_no = r;
  endtask

  task automatic test_reset();
    aresetn = 0;
    clr();
    exp_q.push_back(5'b00000);
    @(negedge aclk); #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL reset_outputs got=%b exp=%b", obs(), exp_v); else passed++;
    total++;
    if ({err_timeout, err_underflow} !== 2'b00)
      $display("FAIL reset_errors got=%b exp=00", {err_timeout, err_underflow});
    else passed++;
    exp_q.push_back(5'b00100);
    @(negedge aclk); aresetn = 1; #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL reset_release got=%b exp=%b", obs(), exp_v); else passed++;
  endtask

  task automatic test_load_use();
    exp_q.push_back(5'b00010);
    cyc(); drive_id(1, 1, 0, 0, 5, 0, 1, 1, 0); #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL load_issue got=%b exp=%b", obs(), exp_v); else passed++;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(c < 2 ? 5'b10100 : 5'b00010);
      cyc(); drive_id(5, 1, 1, 1, 6, 0, 1, 0, 0);
      if (c == 2) begin wb_we = 1; wb_rd_no = 5; end
      #1;
      exp_v = exp_q.pop_front(); total++;
      if (obs() !== exp_v) $display("FAIL load_use_c%0d got=%b exp=%b", c, obs(), exp_v); else passed++;
    end
    commit(6);
    cyc(); #1;
    total++;
    if ({dut.pend_cnt[5], dut.pend_cnt[6]} !== 4'b0000)
      $display("FAIL load_use_cnt got=%b exp=0000", {dut.pend_cnt[5], dut.pend_cnt[6]});
    else passed++;
  endtask

  task automatic test_alu_fwd();
    for (int c = 0; c < 6; c++) begin
      exp_q.push_back(c < 2 ? 5'b00010 : 5'b00100);
      cyc();
      case (c)
        0: drive_id(2, 1, 0, 0, 5, 0, 1, 0, 0);
        1: drive_id(5, 1, 2, 1, 7, 0, 1, 0, 0);
        3: begin wb_we = 1; wb_rd_no = 5; end
        4: begin wb_we = 1; wb_rd_no = 7; end
        default: ;
      endcase
      #1;
      exp_v = exp_q.pop_front(); total++;
      if (obs() !== exp_v) $display("FAIL alu_fwd_c%0d got=%b exp=%b", c, obs(), exp_v); else passed++;
      if (c == 1) begin
        total++;
        if (dut.pend_cnt[5] !== 2'd1) $display("FAIL alu_cnt_up got=%0d exp=1", dut.pend_cnt[5]); else passed++;
      end
      if (c == 4) begin
        total++;
        if (dut.pend_cnt[5] !== 2'd0) $display("FAIL alu_cnt_down got=%0d exp=0", dut.pend_cnt[5]); else passed++;
      end
    end
  endtask

  task automatic test_multi();
    exp_q.push_back(5'b00010);
    cyc(); drive_id(1, 1, 0, 0, 10, 0, 1, 1, 0); #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL multi_ld got=%b exp=%b", obs(), exp_v); else passed++;
    exp_q.push_back(5'b00010);
    cyc(); drive_id(1, 1, 2, 1, 8, 0, 1, 0, 1); #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL multi_issue got=%b exp=%b", obs(), exp_v); else passed++;
    for (int c = 0; c < 11; c++) begin
      exp_q.push_back(c < 10 ? 5'b11001 : 5'b00011);
      cyc(); drive_id(1, 1, 0, 0, 11, 0, 1, 0, 0);
      ex_finish = (c == 10);
      #1;
      exp_v = exp_q.pop_front(); total++;
      if (obs() !== exp_v) $display("FAIL multi_busy_c%0d got=%b exp=%b", c, obs(), exp_v); else passed++;
      if (c == 0 || c == 10) begin
        total++;
        if ({dut.ld_ex_v, dut.ld_mem_v, dut.ld_mem_rd} !== {2'b01, 5'd10})
          $display("FAIL multi_ld_hold_c%0d got=%b exp=0101010", c, {dut.ld_ex_v, dut.ld_mem_v, dut.ld_mem_rd});
        else passed++;
      end
    end
    exp_q.push_back(5'b00100);
    cyc(); #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL multi_done got=%b exp=%b", obs(), exp_v); else passed++;
    commit(10); commit(8); commit(11);
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 5; c++) begin
      exp_q.push_back(c == 3 ? 5'b10100 : 5'b00010);
      cyc(); drive_id(1, 1, 0, 0, 3, 0, 1, 0, 0);
      if (c == 4) begin wb_we = 1; wb_rd_no = 3; end
      #1;
      exp_v = exp_q.pop_front(); total++;
      if (obs() !== exp_v) $display("FAIL sat_c%0d got=%b exp=%b", c, obs(), exp_v); else passed++;
    end
    cyc(); #1;
    total++;
    if (dut.pend_cnt[3] !== 2'd3) $display("FAIL sat_cnt_hold got=%0d exp=3", dut.pend_cnt[3]); else passed++;
    commit(3); commit(3); commit(3);
    cyc(); #1;
    total++;
    if (dut.pend_cnt[3] !== 2'd0) $display("FAIL sat_cnt_drain got=%0d exp=0", dut.pend_cnt[3]); else passed++;
  endtask

  task automatic test_timeout();
    exp_q.push_back(5'b00010);
    cyc(); drive_id(1, 1, 0, 0, 8, 0, 1, 0, 1); #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL to_issue got=%b exp=%b", obs(), exp_v); else passed++;
    for (int k = 1; k <= 67; k++) begin
      cyc();
      ex_finish = (k == 66);
      #1;
      if (k == 1 || k == 66 || k == 67) begin
        exp_q.push_back(k == 1 ? 5'b01001 : (k == 66 ? 5'b00101 : 5'b00100));
        exp_v = exp_q.pop_front(); total++;
        if (obs() !== exp_v) $display("FAIL to_ctl_k%0d got=%b exp=%b", k, obs(), exp_v); else passed++;
      end
      if (k == 64) begin
        total++;
        if (err_timeout !== 1'b0) $display("FAIL to_early got=%b exp=0", err_timeout); else passed++;
      end
      if (k == 65 || k == 67) begin
        total++;
        if (err_timeout !== 1'b1) $display("FAIL to_set_k%0d got=%b exp=1", k, err_timeout); else passed++;
      end
    end
    commit(8);
  endtask

  task automatic test_r0_and_underflow();
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(c < 2 ? 5'b00010 : 5'b00100);
      cyc();
      case (c)
        0: drive_id(0, 1, 0, 0, 0, 0, 1, 1, 0);
        1: drive_id(0, 1, 0, 1, 0, 1, 1, 0, 0);
        default: begin wb_we = 1; wb_rd_no = 0; end
      endcase
      #1;
      exp_v = exp_q.pop_front(); total++;
      if (obs() !== exp_v) $display("FAIL r0_c%0d got=%b exp=%b", c, obs(), exp_v); else passed++;
    end
    cyc(); wb_we = 1; wb_rd_no = 9; #1;
    total++;
    if ({dut.pend_cnt[0], err_underflow} !== 3'b000)
      $display("FAIL r0_untracked got=%b exp=000", {dut.pend_cnt[0], err_underflow});
    else passed++;
    cyc(); #1;
    total++;
    if ({dut.pend_cnt[9], err_underflow} !== 3'b001)
      $display("FAIL underflow got=%b exp=001", {dut.pend_cnt[9], err_underflow});
    else passed++;
  endtask

  task automatic test_reset_mid_busy();
    exp_q.push_back(5'b00010);
    cyc(); drive_id(1, 1, 0, 0, 12, 0, 1, 1, 0); #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL rst_ld got=%b exp=%b", obs(), exp_v); else passed++;
    exp_q.push_back(5'b00010);
    cyc(); drive_id(1, 1, 0, 0, 8, 0, 1, 0, 1); #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL rst_div got=%b exp=%b", obs(), exp_v); else passed++;
    exp_q.push_back(5'b00000);
    cyc(); drive_id(12, 1, 0, 0, 13, 0, 1, 0, 0); aresetn = 0; #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL rst_mid_outputs got=%b exp=%b", obs(), exp_v); else passed++;
    total++;
    if ({err_timeout, err_underflow} !== 2'b00)
      $display("FAIL rst_mid_errors got=%b exp=00", {err_timeout, err_underflow});
    else passed++;
    exp_q.push_back(5'b00010);
    cyc(); drive_id(12, 1, 0, 0, 13, 0, 1, 0, 0); aresetn = 1; #1;
    exp_v = exp_q.pop_front(); total++;
    if (obs() !== exp_v) $display("FAIL rst_consumer got=%b exp=%b", obs(), exp_v); else passed++;
    cyc();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_multi();
    test_saturation();
    test_timeout();
    test_r0_and_underflow();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the pipeline's operand-forwarding network.
- Tracks in-flight register writers from EX through WB, plus loads in EX/MEM.
- Generates stall and bubble controls for the cases forwarding cannot cover: load-use, multi-cycle EX ops, and writer-count saturation.
- Sits beside the ID/EX pipeline registers of the 5-stage core and is driven from ID issue and WB commit.

Parameters:
- NREG, 32: architectural GPR count; r0 is never tracked.
- REG_W, 5: register-number width.
- CNT_W, 2: per-register pending-writer counter width; the maximum count is 2^CNT_W-1.
- TIMEOUT_CYC, 64: number of BUSY cycles before err_timeout is raised.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_flush  in  1  redirect: kill the instruction in ID this cycle.
- id_rj_no, id_rk_no, id_rd_no  in  REG_W each  ID register numbers.
- id_rj_re, id_rk_re, id_rd_re  in  1 each  the ID instruction reads rj/rk/rd (rd read for stores and branches).
- id_we  in  1  the ID instruction writes rd.
- id_is_load  in  1  the ID instruction is a load.
- id_is_multi  in  1  the ID instruction is a multi-cycle EX op (mul/div).
- ex_finish  in  1  the multi-cycle EX op completes this cycle.
- wb_we  in  1  WB commits a register write.
- wb_rd_no  in  REG_W  WB destination register.
- stall_id  out  1  hold IF/ID.
- stall_ex  out  1  hold the EX stage and its operands.
- bubble_ex  out  1  load a NOP into ID/EX.
- id_fire  out  1  the ID instruction issues to EX this cycle.
- ex_busy  out  1  the FSM is in BUSY.
- err_timeout  out  1  sticky: a multi-cycle op exceeded TIMEOUT_CYC.
- err_underflow  out  1  sticky: WB committed to a register with count 0.

Behaviour:
- Reset (async, aresetn=0): all counters, load trackers and error flags clear; FSM enters IDLE.
- Reset values: stall_id=0, stall_ex=0, bubble_ex=0, id_fire=0, ex_busy=0, err_timeout=0, err_underflow=0.
- Asserting reset mid-BUSY aborts the op immediately.
- Source match: a source matches a tracked register only if its read enable is set, its number is nonzero, and the tracker entry is valid.
- Load trackers: two stages, ld_ex and ld_mem, each {valid, rd}.
  - Trackers advance only when stall_ex=0: ld_mem <= ld_ex; ld_ex <= {id_fire & id_is_load & id_we & (id_rd_no!=0), id_rd_no}.
  - When stall_ex=1, both trackers hold.
- load_haz: any ID source matches ld_ex or ld_mem. A load in MEM is not forwardable because its MEM value is an address.
- Pending counters: one per register, for r1..r31.
  - Increment on id_fire & id_we & rd!=0.
  - Decrement on wb_we & wb_rd_no!=0.
  - Increment and decrement of the same register in the same cycle: no change.
  - Decrement at 0: counter holds 0 and err_underflow sets.
- sat_haz: id_we & id_rd_no!=0, the rd count equals its maximum, and no same-cycle decrement of that register.
- FSM, two states:
  - IDLE -> BUSY on id_fire & id_is_multi.
  - BUSY -> IDLE on ex_finish.
  - ex_finish is ignored in IDLE.
  - ex_busy = (state==BUSY).
- stall_ex = BUSY & ~ex_finish.
- stall_id = id_valid & ~id_flush & (load_haz | sat_haz | stall_ex).
- id_fire = id_valid & ~id_flush & ~stall_id. When stall_ex=1, id_fire=0 by construction.
- bubble_ex = ~stall_ex & ~id_fire. This also covers id_flush and an invalid ID.
- Outputs are combinational from state and inputs; zero added latency.
- Load-use penalty: 2 stall cycles; the consumer issues the cycle the load reaches WB, using WB forwarding.
- Timeout counter:
  - Clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC, err_timeout sets (sticky until reset); the FSM stays BUSY and the counter saturates.
- ALU-to-consumer back-to-back needs no stall; MEM-to-EX forwarding covers it.

Test Plan:
- Load then dependent op: ld r5 issues; next cycle add r6,r5,r1 in ID -> stall_id=1 for 2 cycles, bubble_ex=1 for both; the add fires on the 3rd cycle.
- ALU then dependent op: add r5 then sub r7,r5,r2 -> stall_id never asserts; counter[5] reaches 1 and returns to 0 three cycles after the add issues.
- Multi-cycle op: div issues; ex_finish asserted 10 cycles later -> ex_busy=1 and stall_ex=1 for 10 cycles; ld_ex/ld_mem hold; the next ID instruction fires the cycle ex_finish=1.
- Saturation: three back-to-back writers to r3 with WB held off -> 4th writer stalls; a WB commit of r3 in the same cycle releases it with no stall.
- Errors: ex_finish withheld for 64 BUSY cycles -> err_timeout=1 and sticky. wb_we=1, wb_rd_no=9 with count 0 -> err_underflow=1 and counter stays 0. wb_rd_no=0 and r0 reads -> never stall or count.
- Reset mid-BUSY with a load in ld_mem: aresetn pulsed low -> all outputs 0 immediately; a next-cycle consumer of that load does not stall.
